// File: rtl/regfile_plus_pkg.sv
// Shared constants for the banked ARM register file: widths, mode codes and
// the physical storage layout used by the bank mapper and the register array.
package regfile_plus_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int MODE_W   = 5;
  localparam int IDX_W    = 6;
  localparam int NUM_PHYS = 33;

  localparam logic [MODE_W-1:0] MODE_USR = 5'b10000;
  localparam logic [MODE_W-1:0] MODE_FIQ = 5'b10001;
  localparam logic [MODE_W-1:0] MODE_IRQ = 5'b10010;
  localparam logic [MODE_W-1:0] MODE_SVC = 5'b10011;
  localparam logic [MODE_W-1:0] MODE_MON = 5'b10110;
  localparam logic [MODE_W-1:0] MODE_ABT = 5'b10111;
  localparam logic [MODE_W-1:0] MODE_HYP = 5'b11010;
  localparam logic [MODE_W-1:0] MODE_UND = 5'b11011;
  localparam logic [MODE_W-1:0] MODE_SYS = 5'b11111;

  typedef logic [IDX_W-1:0] phys_idx_t;

  // Physical layout: 0-7 shared low registers, 8-12 user R8-R12,
  // 13-17 FIQ R8-R12, then R13/R14 pairs per bank, R13_hyp last.
  localparam phys_idx_t IDX_FIQ_R8  = 6'd13;
  localparam phys_idx_t IDX_USR_R13 = 6'd18;
  localparam phys_idx_t IDX_USR_R14 = 6'd19;
  localparam phys_idx_t IDX_FIQ_R13 = 6'd20;
  localparam phys_idx_t IDX_IRQ_R13 = 6'd22;
  localparam phys_idx_t IDX_SVC_R13 = 6'd24;
  localparam phys_idx_t IDX_MON_R13 = 6'd26;
  localparam phys_idx_t IDX_ABT_R13 = 6'd28;
  localparam phys_idx_t IDX_UND_R13 = 6'd30;
  localparam phys_idx_t IDX_HYP_R13 = 6'd32;

  // Physical slot of R13 for a mode; R14 of the same bank sits one above
  // (except HYP, which borrows the user R14).
  function automatic phys_idx_t bank_r13_idx(input logic [MODE_W-1:0] mode);
    case (mode)
      MODE_FIQ:           return IDX_FIQ_R13;
      MODE_IRQ:           return IDX_IRQ_R13;
      MODE_SVC:           return IDX_SVC_R13;
      MODE_MON:           return IDX_MON_R13;
      MODE_ABT:           return IDX_ABT_R13;
      MODE_UND:           return IDX_UND_R13;
      MODE_HYP:           return IDX_HYP_R13;
      MODE_USR, MODE_SYS: return IDX_USR_R13;
      default:            return IDX_USR_R13;
    endcase
  endfunction

endpackage

// File: rtl/regfile_bank_map.sv
// Translates (mode, architectural register number) into a physical storage
// slot; address 15 is flagged as the PC instead of a banked register.
module regfile_bank_map
  import regfile_plus_pkg::*;
(
  input  logic [MODE_W-1:0] mode,
  input  logic [ADDR_W-1:0] addr,
  output phys_idx_t         idx,
  output logic              is_pc
);

  phys_idx_t r13_idx;

  assign r13_idx = bank_r13_idx(mode);

  // NOTE: every output gets a default at the top of always_comb so no path
  // through the if/else chain can leave it unassigned and infer a latch.
  always_comb begin
    idx   = '0;
    is_pc = 1'b0;
    if (addr == 4'd15) begin
      is_pc = 1'b1;
    end else if (addr < 4'd8) begin
      idx = phys_idx_t'(addr);
    end else if (addr <= 4'd12) begin
      idx = (mode == MODE_FIQ) ? IDX_FIQ_R8 + phys_idx_t'(addr - 4'd8)
                               : phys_idx_t'(addr);
    end else if (addr == 4'd13) begin
      idx = r13_idx;
    end else begin
      idx = (mode == MODE_HYP) ? IDX_USR_R14 : r13_idx + 6'd1;
    end
  end

endmodule

// File: rtl/regfile_plus.sv
// ARM-style banked register file: 33 physical registers plus PC, three
// combinational read ports, one write port and an independent PC load.
module regfile_plus
  import regfile_plus_pkg::*;
(
  input  logic              clk,
  input  logic              Rst,
  input  logic [MODE_W-1:0] M,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  input  logic [ADDR_W-1:0] R_Addr_C,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [DATA_W-1:0] W_Data,
  input  logic              Write_Reg,
  input  logic [DATA_W-1:0] PC_New,
  input  logic              Write_PC,
  output logic [DATA_W-1:0] R_Data_A,
  output logic [DATA_W-1:0] R_Data_B,
  output logic [DATA_W-1:0] R_Data_C,
  output logic [DATA_W-1:0] PC
);

  logic [DATA_W-1:0] regs [NUM_PHYS];
  logic [DATA_W-1:0] pc_q;

  phys_idx_t a_idx, b_idx, c_idx, w_idx;
  logic      a_is_pc, b_is_pc, c_is_pc, w_is_pc;

  regfile_bank_map u_map_a (.mode(M), .addr(R_Addr_A), .idx(a_idx), .is_pc(a_is_pc));
  regfile_bank_map u_map_b (.mode(M), .addr(R_Addr_B), .idx(b_idx), .is_pc(b_is_pc));
  regfile_bank_map u_map_c (.mode(M), .addr(R_Addr_C), .idx(c_idx), .is_pc(c_is_pc));
  regfile_bank_map u_map_w (.mode(M), .addr(W_Addr),   .idx(w_idx), .is_pc(w_is_pc));

  // NOTE: the array is cleared by reset because software relies on every
  // register reading zero afterwards; this forces flops rather than RAM.
  // NOTE: sequential state uses non-blocking assignment so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NUM_PHYS; i++) regs[i] <= '0;
      pc_q <= '0;
    end else begin
      if (Write_Reg && !w_is_pc) regs[w_idx] <= W_Data;
      // The fetch-stage PC load has priority over a register write to R15.
      if (Write_PC)                pc_q <= PC_New;
      else if (Write_Reg && w_is_pc) pc_q <= W_Data;
    end
  end

  assign R_Data_A = a_is_pc ? pc_q : regs[a_idx];
  assign R_Data_B = b_is_pc ? pc_q : regs[b_idx];
  assign R_Data_C = c_is_pc ? pc_q : regs[c_idx];
  assign PC       = pc_q;

endmodule

// File: tb/tb_regfile_plus.sv
// Self-checking bench for regfile_plus: directed banking scenarios plus random
// traffic compared against a per-bank behavioural model.
`timescale 1ns/1ps
module tb_regfile_plus;
  import regfile_plus_pkg::*;

  logic        clk = 1'b0;
  logic        Rst;
  logic [4:0]  M;
  logic [3:0]  R_Addr_A, R_Addr_B, R_Addr_C, W_Addr;
  logic [31:0] W_Data, PC_New;
  logic        Write_Reg, Write_PC;
  logic [31:0] R_Data_A, R_Data_B, R_Data_C, PC;

  int n_vec = 0;
  int n_err = 0;

  regfile_plus dut (
    .clk(clk), .Rst(Rst), .M(M),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .R_Addr_C(R_Addr_C),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .PC_New(PC_New), .Write_PC(Write_PC),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B), .R_Data_C(R_Data_C), .PC(PC)
  );

  always #5 clk = ~clk;

  // Reference model: architectural view per bank, not per physical slot.
  logic [31:0] m_low [8];
  logic [31:0] m_usr [16];
  logic [31:0] m_fiq [16];
  logic [31:0] m_sp  [int];
  logic [31:0] m_lr  [int];
  logic [31:0] m_pc;

  logic [4:0] modes [11];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int canon(input logic [4:0] m);
    if (m == MODE_FIQ || m == MODE_IRQ || m == MODE_SVC || m == MODE_MON ||
        m == MODE_ABT || m == MODE_HYP || m == MODE_UND)
      return int'(m);
    return int'(MODE_USR);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_low[i] = '0;
    for (int i = 0; i < 16; i++) begin m_usr[i] = '0; m_fiq[i] = '0; end
    for (int i = 0; i < 11; i++) begin
      m_sp[canon(modes[i])] = '0;
      m_lr[canon(modes[i])] = '0;
    end
    m_pc = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] m, input logic [3:0] a);
    int c;
    c = canon(m);
    if (a == 4'd15) return m_pc;
    if (a < 4'd8)   return m_low[a];
    if (a <= 4'd12) return (c == int'(MODE_FIQ)) ? m_fiq[a] : m_usr[a];
    if (a == 4'd13) return m_sp[c];
    return m_lr[(c == int'(MODE_HYP)) ? int'(MODE_USR) : c];
  endfunction

  task automatic m_write(input logic [4:0] m, input logic [3:0] a, input logic [31:0] d);
    int c;
    c = canon(m);
    if (a < 4'd8)                        m_low[a] = d;
    else if (a <= 4'd12 && c == int'(MODE_FIQ)) m_fiq[a] = d;
    else if (a <= 4'd12)                 m_usr[a] = d;
    else if (a == 4'd13)                 m_sp[c] = d;
    else if (c == int'(MODE_HYP))        m_lr[int'(MODE_USR)] = d;
    else                                 m_lr[c] = d;
  endtask

  // One clock: drive at negedge, check pre-edge reads, edge, check post-edge.
  task automatic cycle(input logic [4:0] m, input logic [3:0] wa, input logic [31:0] wd,
                       input logic wr, input logic [31:0] pcn, input logic wpc,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    @(negedge clk);
    M = m; W_Addr = wa; W_Data = wd; Write_Reg = wr; PC_New = pcn; Write_PC = wpc;
    R_Addr_A = a; R_Addr_B = b; R_Addr_C = c;
    #1;
    check("pre_A", R_Data_A, m_read(m, a));
    check("pre_B", R_Data_B, m_read(m, b));
    check("pre_C", R_Data_C, m_read(m, c));
    @(posedge clk);
    if (wpc) m_pc = pcn;
    else if (wr && wa == 4'd15) m_pc = wd;
    if (wr && wa != 4'd15) m_write(m, wa, wd);
    #1;
    check("post_A", R_Data_A, m_read(m, a));
    check("post_B", R_Data_B, m_read(m, b));
    check("post_C", R_Data_C, m_read(m, c));
    check("post_PC", PC, m_pc);
  endtask

  // Combinational read of three registers against fixed expectations.
  task automatic expect3(input string tag, input logic [4:0] m,
                         input logic [3:0] a, input logic [31:0] ea,
                         input logic [3:0] b, input logic [31:0] eb,
                         input logic [3:0] c, input logic [31:0] ec);
    Write_Reg = 1'b0; Write_PC = 1'b0;
    M = m; R_Addr_A = a; R_Addr_B = b; R_Addr_C = c;
    #1;
    check({tag, "_A"}, R_Data_A, ea);
    check({tag, "_B"}, R_Data_B, eb);
    check({tag, "_C"}, R_Data_C, ec);
  endtask

  initial begin
    modes = '{MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_MON, MODE_ABT,
              MODE_HYP, MODE_UND, MODE_SYS, 5'b00000, 5'b10101};
    Rst = 1'b1; M = MODE_USR; W_Addr = '0; W_Data = '0; Write_Reg = 1'b0;
    PC_New = '0; Write_PC = 1'b0; R_Addr_A = '0; R_Addr_B = 4'd7; R_Addr_C = 4'd15;
    model_reset();

    // Reset state, with a write attempt that must be ignored.
    repeat (2) @(negedge clk);
    Write_Reg = 1'b1; W_Data = 32'hDEADBEEF; Write_PC = 1'b1; PC_New = 32'h1234;
    @(negedge clk);
    check("rst_pc", PC, 32'h0);
    expect3("rst", MODE_USR, 4'd0, 32'h0, 4'd7, 32'h0, 4'd15, 32'h0);
    @(negedge clk);
    Rst = 1'b0;
    for (int r = 0; r < 16; r += 3)
      expect3("post_rst", MODE_USR, 4'(r), 32'h0, 4'(r + 1), 32'h0, 4'(r + 2), 32'h0);

    // USR writes with simultaneous PC updates.
    cycle(MODE_USR, 4'd2,  32'hFFFFFFFF, 1'b1, 32'h00000008, 1'b1, 4'd2, 4'd11, 4'd13);
    check("usr_pc0", PC, 32'h00000008);
    cycle(MODE_USR, 4'd11, 32'hAAAAAAAA, 1'b1, 32'hF0F0F0F0, 1'b1, 4'd2, 4'd11, 4'd13);
    cycle(MODE_USR, 4'd13, 32'h40404040, 1'b1, 32'h87654321, 1'b1, 4'd2, 4'd11, 4'd13);
    check("usr_pc2", PC, 32'h87654321);
    expect3("usr", MODE_USR, 4'd2, 32'hFFFFFFFF, 4'd11, 32'hAAAAAAAA, 4'd13, 32'h40404040);

    // FIQ banking of R8-R14.
    cycle(MODE_FIQ, 4'd5,  32'h3F3F3F3F, 1'b1, 32'h0, 1'b0, 4'd5, 4'd9, 4'd14);
    cycle(MODE_FIQ, 4'd9,  32'hF3F3F3F3, 1'b1, 32'h0, 1'b0, 4'd5, 4'd9, 4'd14);
    cycle(MODE_FIQ, 4'd14, 32'h63636363, 1'b1, 32'h0, 1'b0, 4'd5, 4'd9, 4'd14);
    expect3("fiq_as_usr", MODE_USR, 4'd5, 32'h3F3F3F3F, 4'd9, 32'h0, 4'd14, 32'h0);
    expect3("fiq_back",   MODE_FIQ, 4'd5, 32'h3F3F3F3F, 4'd9, 32'hF3F3F3F3, 4'd14, 32'h63636363);

    // ABT: R15 write via the register port, R8 lands in the user copy.
    cycle(MODE_ABT, 4'd1,  32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 4'd1, 4'd8, 4'd15);
    cycle(MODE_ABT, 4'd15, 32'hAAAAAAAA, 1'b1, 32'h0, 1'b0, 4'd1, 4'd8, 4'd15);
    check("abt_pc", PC, 32'hAAAAAAAA);
    cycle(MODE_ABT, 4'd8,  32'h40404040, 1'b1, 32'h0, 1'b0, 4'd1, 4'd8, 4'd15);
    expect3("abt_as_usr", MODE_USR, 4'd1, 32'hFFFFFFFF, 4'd8, 32'h40404040, 4'd15, 32'hAAAAAAAA);

    // HYP: own R13, shared R12 and R14.
    cycle(MODE_HYP, 4'd5,  32'h12345678, 1'b1, 32'h0, 1'b0, 4'd5, 4'd13, 4'd12);
    cycle(MODE_HYP, 4'd13, 32'hF3F3F3F3, 1'b1, 32'h0, 1'b0, 4'd5, 4'd13, 4'd12);
    cycle(MODE_HYP, 4'd12, 32'h63636363, 1'b1, 32'h0, 1'b0, 4'd5, 4'd13, 4'd12);
    expect3("hyp_as_usr", MODE_USR, 4'd12, 32'h63636363, 4'd13, 32'h40404040, 4'd5, 32'h12345678);
    expect3("hyp",        MODE_HYP, 4'd13, 32'hF3F3F3F3, 4'd14, 32'h0, 4'd9, 32'h0);

    // SYS shares the user bank; idle cycles leave everything alone.
    cycle(MODE_SYS, 4'd6,  32'h55AA55AA, 1'b1, 32'h0, 1'b0, 4'd6, 4'd10, 4'd14);
    cycle(MODE_SYS, 4'd10, 32'h81818181, 1'b1, 32'h0, 1'b0, 4'd6, 4'd10, 4'd14);
    cycle(MODE_SYS, 4'd14, 32'hF3F3F3F3, 1'b1, 32'h0, 1'b0, 4'd6, 4'd10, 4'd14);
    expect3("sys_as_usr", MODE_USR, 4'd6, 32'h55AA55AA, 4'd10, 32'h81818181, 4'd14, 32'hF3F3F3F3);
    for (int i = 0; i < 4; i++)
      cycle(modes[i], 4'(i), 32'hBADBAD00, 1'b0, 32'h0, 1'b0, 4'(i + 10), 4'd13, 4'd14);

    // Write_PC wins over a simultaneous register write to R15.
    cycle(MODE_SVC, 4'd15, 32'hDEADBEEF, 1'b1, 32'h00000100, 1'b1, 4'd15, 4'd13, 4'd14);
    check("pc_prio", PC, 32'h00000100);

    // Random traffic across all modes, including undefined codes.
    for (int i = 0; i < 400; i++)
      cycle(modes[$urandom_range(0, 10)], 4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 4) == 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    // Asynchronous reset: clears with no clock edge in between.
    cycle(MODE_FIQ, 4'd9, 32'h13579BDF, 1'b1, 32'h2468ACE0, 1'b1, 4'd9, 4'd14, 4'd15);
    @(negedge clk);
    #1;
    Rst = 1'b1;
    model_reset();
    #1;
    check("arst_pc", PC, 32'h0);
    expect3("arst", MODE_FIQ, 4'd9, 32'h0, 4'd14, 32'h0, 4'd15, 32'h0);
    for (int i = 0; i < 11; i++)
      expect3("arst_sweep", modes[i], 4'd8, m_read(modes[i], 4'd8),
              4'd13, m_read(modes[i], 4'd13), 4'd14, m_read(modes[i], 4'd14));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
